dmem_xif_arbiter: RTL and testbench

- Shares the single scalar data-memory bus (separate read and write channels) between the srv32 core's load/store unit and the vector unit's XIF memory interface.
- Sits between the core/XIF mem channel and the CLINT/dmem address split.
- Core has default priority; a starvation counter guarantees vector progress; vector multi-beat transactions (last=0) lock the bus until their final beat.
- Generates the XIF mem_ready/mem_result handshake with a one-cycle result register.

---
 rtl/dmem_xif_arbiter_if.sv | 58 +++++
 rtl/dmem_xif_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_xif_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_xif_arbiter_if.sv
// Bundle of core LSU, vector XIF mem and data-memory bus signals shared by the arbiter
// (slave view) and its surrounding environment (master view).
interface dmem_xif_arbiter_if #(
  parameter int unsigned ID_W = 3
);
  logic            c_wready;
  logic            c_wvalid;
  logic [31:0]     c_waddr;
  logic [31:0]     c_wdata;
  logic [3:0]      c_wstrb;
  logic            c_rready;
  logic            c_rvalid;
  logic [31:0]     c_raddr;
  logic            c_rresp;
  logic [31:0]     c_rdata;

  logic            v_mem_valid;
  logic            v_mem_ready;
  logic [ID_W-1:0] v_mem_id;
  logic [31:0]     v_mem_addr;
  logic [31:0]     v_mem_wdata;
  logic            v_mem_we;
  logic [3:0]      v_mem_be;
  logic            v_mem_last;
  logic            v_res_valid;
  logic [ID_W-1:0] v_res_id;
  logic [31:0]     v_res_rdata;
  logic            v_res_err;

  logic            m_wready;
  logic            m_wvalid;
  logic [31:0]     m_waddr;
  logic [31:0]     m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_rready;
  logic            m_rvalid;
  logic [31:0]     m_raddr;
  logic            m_rresp;
  logic [31:0]     m_rdata;

  modport slave (
    input  c_wready, c_waddr, c_wdata, c_wstrb, c_rready, c_raddr,
    output c_wvalid, c_rvalid, c_rresp, c_rdata,
    input  v_mem_valid, v_mem_id, v_mem_addr, v_mem_wdata, v_mem_we, v_mem_be, v_mem_last,
    output v_mem_ready, v_res_valid, v_res_id, v_res_rdata, v_res_err,
    output m_wready, m_waddr, m_wdata, m_wstrb, m_rready, m_raddr,
    input  m_wvalid, m_rvalid, m_rresp, m_rdata
  );

  modport master (
    output c_wready, c_waddr, c_wdata, c_wstrb, c_rready, c_raddr,
    input  c_wvalid, c_rvalid, c_rresp, c_rdata,
    output v_mem_valid, v_mem_id, v_mem_addr, v_mem_wdata, v_mem_we, v_mem_be, v_mem_last,
    input  v_mem_ready, v_res_valid, v_res_id, v_res_rdata, v_res_err,
    input  m_wready, m_waddr, m_wdata, m_wstrb, m_rready, m_raddr,
    output m_wvalid, m_rvalid, m_rresp, m_rdata
  );
endinterface

// File: rtl/dmem_xif_arbiter.sv
// Arbitrates the scalar data-memory read/write channels between the core LSU and the vector
// XIF mem interface: core-first priority, starvation override, burst lock, XIF result pulse.
module dmem_xif_arbiter #(
  parameter int unsigned ID_W       = 3,
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned LOCK_TMO   = 64
) (
  input logic               clk,
  input logic               resetb,
  dmem_xif_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  localparam int unsigned TW = $clog2(LOCK_TMO + 1);

  typedef enum logic [0:0] {StArb, StVLock} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            res_valid_q, res_valid_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic            res_we_q, res_we_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_vec_q, rd_vec_d;

  logic v_wr, v_rd, starved, tmo_hit, locked;
  logic gnt_cw, gnt_cr, gnt_vw, gnt_vr;
  logic v_acc, r_acc, res_load, core_ret;

  always_comb begin
    v_wr    = bus.v_mem_valid & bus.v_mem_we;
    v_rd    = bus.v_mem_valid & ~bus.v_mem_we;
    starved = (starve_q == SW'(STARVE_LIM));
    // The lock is released in the very cycle the idle timer expires.
    tmo_hit = (state_q == StVLock) & ~bus.v_mem_valid & (tmo_q == TW'(LOCK_TMO - 1));
    locked  = (state_q == StVLock) & ~tmo_hit;
    if (locked) begin
      gnt_vw = v_wr;
      gnt_vr = v_rd;
      gnt_cw = 1'b0;
      gnt_cr = 1'b0;
    end else begin
      gnt_vw = v_wr & (~bus.c_wready | starved);
      gnt_vr = v_rd & (~bus.c_rready | starved);
      gnt_cw = bus.c_wready & ~gnt_vw;
      gnt_cr = bus.c_rready & ~gnt_vr;
    end
    // Keep every combinational output quiet while reset is asserted.
    gnt_vw = gnt_vw & resetb;
    gnt_vr = gnt_vr & resetb;
    gnt_cw = gnt_cw & resetb;
    gnt_cr = gnt_cr & resetb;
    v_acc  = (gnt_vw & bus.m_wvalid) | (gnt_vr & bus.m_rvalid);
    r_acc  = (gnt_cr | gnt_vr) & bus.m_rvalid;
  end

  always_comb begin
    bus.m_wready = gnt_cw | gnt_vw;
    bus.m_waddr  = '0;
    bus.m_wdata  = '0;
    bus.m_wstrb  = '0;
    if (gnt_vw) begin
      bus.m_waddr = bus.v_mem_addr;
      bus.m_wdata = bus.v_mem_wdata;
      bus.m_wstrb = bus.v_mem_be;
    end else if (gnt_cw) begin
      bus.m_waddr = bus.c_waddr;
      bus.m_wdata = bus.c_wdata;
      bus.m_wstrb = bus.c_wstrb;
    end
    bus.m_rready = gnt_cr | gnt_vr;
    bus.m_raddr  = gnt_vr ? bus.v_mem_addr : (gnt_cr ? bus.c_raddr : '0);

    bus.c_wvalid    = gnt_cw & bus.m_wvalid;
    bus.c_rvalid    = gnt_cr & bus.m_rvalid;
    bus.v_mem_ready = v_acc;

    core_ret        = rd_pend_q & ~rd_vec_q;
    bus.c_rdata     = core_ret ? bus.m_rdata : '0;
    bus.c_rresp     = core_ret & bus.m_rresp;

    res_load        = res_valid_q & ~res_we_q;
    bus.v_res_valid = res_valid_q;
    bus.v_res_id    = res_id_q;
    bus.v_res_rdata = res_load ? bus.m_rdata : '0;
    bus.v_res_err   = res_load & ~bus.m_rresp;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (v_acc && !bus.v_mem_last) state_d = StVLock;
      StVLock: if ((v_acc && bus.v_mem_last) || tmo_hit) state_d = StArb;
      default: state_d = StArb;
    endcase

    starve_d = starve_q;
    if (v_acc) begin
      starve_d = '0;
    end else if (bus.v_mem_valid && !starved) begin
      starve_d = starve_q + SW'(1);
    end

    tmo_d = '0;
    if (state_q == StVLock && !v_acc && !bus.v_mem_valid && !tmo_hit) begin
      tmo_d = tmo_q + TW'(1);
    end

    res_valid_d = v_acc;
    res_id_d    = v_acc ? bus.v_mem_id : res_id_q;
    res_we_d    = v_acc ? bus.v_mem_we : res_we_q;
    rd_pend_d   = r_acc;
    rd_vec_d    = r_acc ? gnt_vr : rd_vec_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= StArb;
      starve_q    <= '0;
      tmo_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_we_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_vec_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_we_q    <= res_we_d;
      rd_pend_q   <= rd_pend_d;
      rd_vec_q    <= rd_vec_d;
    end
  end
endmodule

// File: tb/tb_dmem_xif_arbiter.sv
// Directed bench for dmem_xif_arbiter: always-accepting memory model returning addr^0xA5A50000.
module tb_dmem_xif_arbiter;
  logic clk = 1'b0;
  logic resetb;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        mem_rresp_cfg;
  logic [31:0] mem_rdata_q;
  logic        mem_rresp_q;
  int          wr_cnt;
  logic [31:0] last_waddr;

  always #5 clk = ~clk;

  dmem_xif_arbiter_if #(.ID_W(3)) bus ();

  dmem_xif_arbiter #(
    .ID_W      (3),
    .STARVE_LIM(8),
    .LOCK_TMO  (64)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus)
  );

  assign bus.m_wvalid = 1'b1;
  assign bus.m_rvalid = 1'b1;
  assign bus.m_rdata  = mem_rdata_q;
  assign bus.m_rresp  = mem_rresp_q;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mem_rdata_q <= '0;
      mem_rresp_q <= 1'b0;
      wr_cnt      <= 0;
      last_waddr  <= '0;
    end else begin
      if (bus.m_rready && bus.m_rvalid) begin
        mem_rdata_q <= bus.m_raddr ^ 32'hA5A5_0000;
        mem_rresp_q <= mem_rresp_cfg;
      end
      if (bus.m_wready && bus.m_wvalid) begin
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= bus.m_waddr;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.c_wready = 0; bus.c_waddr = '0; bus.c_wdata = '0; bus.c_wstrb = '0;
    bus.c_rready = 0; bus.c_raddr = '0;
    bus.v_mem_valid = 0; bus.v_mem_id = '0; bus.v_mem_addr = '0; bus.v_mem_wdata = '0;
    bus.v_mem_we = 0; bus.v_mem_be = '0; bus.v_mem_last = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    clear_inputs();
    mem_rresp_cfg = 1'b1;
    next_cycle();
    next_cycle();
    resetb = 1'b1;
  endtask

  task automatic vec_req(input logic [2:0] id, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be, input logic last);
    bus.v_mem_valid = 1; bus.v_mem_id = id; bus.v_mem_addr = addr; bus.v_mem_we = we;
    bus.v_mem_wdata = wdata; bus.v_mem_be = be; bus.v_mem_last = last;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    clear_inputs();
    mem_rresp_cfg = 1'b1;
    bus.c_rready = 1; bus.c_raddr = 32'h1234_5678;
    bus.c_wready = 1; bus.c_waddr = 32'h1234_0000; bus.c_wdata = 32'hDEAD_BEEF;
    vec_req(3'd1, 32'h5555_0000, 1'b0, '0, 4'hF, 1'b1);
    @(negedge clk);
    if (bus.m_rready !== 1'b0) begin
      $display("FAIL rst_m_rready: got %b want 0", bus.m_rready); n_fail++; end
    n_chk++;
    if (bus.m_raddr !== 32'h0) begin
      $display("FAIL rst_m_raddr: got %h want 0", bus.m_raddr); n_fail++; end
    n_chk++;
    if ({bus.m_wready, bus.m_waddr, bus.m_wdata, bus.m_wstrb} !== '0) begin
      $display("FAIL rst_m_write: got %b/%h/%h/%h want all 0", bus.m_wready, bus.m_waddr,
               bus.m_wdata, bus.m_wstrb); n_fail++; end
    n_chk++;
    if ({bus.c_wvalid, bus.c_rvalid, bus.c_rresp, bus.v_mem_ready} !== 4'b0) begin
      $display("FAIL rst_handshake: got %b want 0000",
               {bus.c_wvalid, bus.c_rvalid, bus.c_rresp, bus.v_mem_ready}); n_fail++; end
    n_chk++;
    if ({bus.v_res_valid, bus.v_res_id, bus.v_res_err, bus.v_res_rdata, bus.c_rdata} !== '0) begin
      $display("FAIL rst_results: got %b/%h/%b/%h/%h want all 0", bus.v_res_valid, bus.v_res_id,
               bus.v_res_err, bus.v_res_rdata, bus.c_rdata); n_fail++; end
    n_chk++;
    clear_inputs();
    next_cycle();
    resetb = 1'b1;
  endtask

  // Core read and vector load collide: core first, vector next cycle.
  task automatic test_read_contend();
    bus.c_rready = 1; bus.c_raddr = 32'h1000_0040;
    vec_req(3'd2, 32'h1000_0080, 1'b0, '0, 4'hF, 1'b1);
    @(negedge clk);
    if (bus.c_rvalid !== 1'b1 || bus.v_mem_ready !== 1'b0) begin
      $display("FAIL t1_c0_grant: got c_rvalid=%b v_mem_ready=%b want 1/0",
               bus.c_rvalid, bus.v_mem_ready); n_fail++; end
    n_chk++;
    if (bus.m_raddr !== 32'h1000_0040) begin
      $display("FAIL t1_c0_raddr: got %h want 10000040", bus.m_raddr); n_fail++; end
    n_chk++;
    next_cycle();
    bus.c_rready = 0;
    @(negedge clk);
    if (bus.c_rdata !== 32'hB5A5_0040 || bus.c_rresp !== 1'b1) begin
      $display("FAIL t1_c1_core_ret: got %h/%b want b5a50040/1", bus.c_rdata, bus.c_rresp);
      n_fail++; end
    n_chk++;
    if (bus.v_mem_ready !== 1'b1 || bus.m_raddr !== 32'h1000_0080) begin
      $display("FAIL t1_c1_vec_acc: got ready=%b raddr=%h want 1/10000080",
               bus.v_mem_ready, bus.m_raddr); n_fail++; end
    n_chk++;
    next_cycle();
    bus.v_mem_valid = 0;
    @(negedge clk);
    if (bus.v_res_valid !== 1'b1 || bus.v_res_id !== 3'd2) begin
      $display("FAIL t1_c2_res: got valid=%b id=%0d want 1/2", bus.v_res_valid, bus.v_res_id);
      n_fail++; end
    n_chk++;
    if (bus.v_res_rdata !== 32'hB5A5_0080 || bus.v_res_err !== 1'b0) begin
      $display("FAIL t1_c2_rdata: got %h/%b want b5a50080/0", bus.v_res_rdata, bus.v_res_err);
      n_fail++; end
    n_chk++;
    if (bus.c_rdata !== 32'h0 || bus.c_rresp !== 1'b0) begin
      $display("FAIL t1_c2_core_masked: got %h/%b want 0/0", bus.c_rdata, bus.c_rresp);
      n_fail++; end
    n_chk++;
    next_cycle();
    @(negedge clk);
    if (bus.v_res_valid !== 1'b0) begin
      $display("FAIL t1_c3_pulse: got %b want 0", bus.v_res_valid); n_fail++; end
    n_chk++;
    next_cycle();
  endtask

  // Continuous core reads starve a vector load until the 8th loss.
  task automatic test_starve();
    for (int k = 0; k <= 9; k++) begin
      bus.c_rready = 1; bus.c_raddr = 32'h2000_0000;
      if (k <= 8) vec_req(3'd5, 32'h3000_0000, 1'b0, '0, 4'hF, 1'b1);
      else bus.v_mem_valid = 0;
      @(negedge clk);
      if (bus.c_rvalid !== (k != 8) || bus.v_mem_ready !== (k == 8)) begin
        $display("FAIL t2_grant_k%0d: got c_rvalid=%b v_mem_ready=%b want %b/%b", k,
                 bus.c_rvalid, bus.v_mem_ready, k != 8, k == 8); n_fail++; end
      n_chk++;
      if (k == 1) begin
        if (bus.c_rdata !== 32'h85A5_0000 || bus.c_rresp !== 1'b1) begin
          $display("FAIL t2_core_data: got %h/%b want 85a50000/1", bus.c_rdata, bus.c_rresp);
          n_fail++; end
        n_chk++;
      end
      if (k == 9) begin
        if (bus.v_res_valid !== 1'b1 || bus.v_res_id !== 3'd5) begin
          $display("FAIL t2_res: got %b/%0d want 1/5", bus.v_res_valid, bus.v_res_id);
          n_fail++; end
        n_chk++;
        if (dut.starve_q !== '0) begin
          $display("FAIL t2_starve_clr: got %0d want 0", dut.starve_q); n_fail++; end
        n_chk++;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // Four-beat vector store burst locks out continuous core writes.
  task automatic test_burst_lock();
    int b;
    for (int k = 0; k <= 12; k++) begin
      b = (k <= 8) ? 0 : k - 8;
      bus.c_wready = 1; bus.c_waddr = 32'h4000_0000; bus.c_wdata = 32'h1111_1111;
      bus.c_wstrb = 4'hF;
      if (k <= 11) vec_req(3'd4, 32'h5000_0000 + 32'(4 * b), 1'b1, 32'h5555_0000 + 32'(b),
                           4'b0011, b == 3);
      else bus.v_mem_valid = 0;
      @(negedge clk);
      if (bus.c_wvalid !== (k < 8 || k == 12) || bus.v_mem_ready !== (k >= 8 && k <= 11)) begin
        $display("FAIL t3_grant_k%0d: got c_wvalid=%b v_mem_ready=%b", k, bus.c_wvalid,
                 bus.v_mem_ready); n_fail++; end
      n_chk++;
      if (k >= 8 && k <= 11) begin
        if (bus.m_waddr !== 32'h5000_0000 + 32'(4 * (k - 8)) || bus.m_wstrb !== 4'b0011) begin
          $display("FAIL t3_vec_mux_k%0d: got %h/%b want %h/0011", k, bus.m_waddr, bus.m_wstrb,
                   32'h5000_0000 + 32'(4 * (k - 8))); n_fail++; end
        n_chk++;
      end
      if (k >= 9) begin
        if (bus.v_res_valid !== 1'b1 || bus.v_res_rdata !== 32'h0 || bus.v_res_err !== 1'b0) begin
          $display("FAIL t3_store_res_k%0d: got %b/%h/%b want 1/0/0", k, bus.v_res_valid,
                   bus.v_res_rdata, bus.v_res_err); n_fail++; end
        n_chk++;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // Vector load errors while a core write proceeds on the other channel.
  task automatic test_load_err();
    int wc0;
    wc0 = wr_cnt;
    mem_rresp_cfg = 1'b0;
    bus.c_wready = 1; bus.c_waddr = 32'h7000_0000; bus.c_wdata = 32'hCAFE_0001;
    bus.c_wstrb = 4'hF;
    vec_req(3'd6, 32'h6000_0010, 1'b0, '0, 4'hF, 1'b1);
    @(negedge clk);
    if (bus.c_wvalid !== 1'b1 || bus.v_mem_ready !== 1'b1) begin
      $display("FAIL t4_both: got c_wvalid=%b v_mem_ready=%b want 1/1", bus.c_wvalid,
               bus.v_mem_ready); n_fail++; end
    n_chk++;
    if (bus.m_waddr !== 32'h7000_0000 || bus.m_raddr !== 32'h6000_0010) begin
      $display("FAIL t4_addrs: got w=%h r=%h want 70000000/60000010", bus.m_waddr, bus.m_raddr);
      n_fail++; end
    n_chk++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    if (bus.v_res_valid !== 1'b1 || bus.v_res_err !== 1'b1 || bus.v_res_id !== 3'd6) begin
      $display("FAIL t4_err: got valid=%b err=%b id=%0d want 1/1/6", bus.v_res_valid,
               bus.v_res_err, bus.v_res_id); n_fail++; end
    n_chk++;
    if (bus.v_res_rdata !== 32'hC5A5_0010) begin
      $display("FAIL t4_rdata: got %h want c5a50010", bus.v_res_rdata); n_fail++; end
    n_chk++;
    if (wr_cnt !== wc0 + 1 || last_waddr !== 32'h7000_0000) begin
      $display("FAIL t4_core_wr: got cnt=%0d addr=%h want %0d/70000000", wr_cnt, last_waddr,
               wc0 + 1); n_fail++; end
    n_chk++;
    mem_rresp_cfg = 1'b1;
    next_cycle();
  endtask

  // Lock held by an abandoned burst drops after 64 idle cycles.
  task automatic test_lock_timeout();
    vec_req(3'd1, 32'h8000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b0);
    @(negedge clk);
    if (bus.v_mem_ready !== 1'b1) begin
      $display("FAIL t5_first_beat: got %b want 1", bus.v_mem_ready); n_fail++; end
    n_chk++;
    next_cycle();
    bus.v_mem_valid = 0;
    bus.c_rready = 1; bus.c_raddr = 32'h9000_0000;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (bus.c_rvalid !== (k == 64)) begin
        $display("FAIL t5_core_k%0d: got c_rvalid=%b want %b", k, bus.c_rvalid, k == 64);
        n_fail++; end
      n_chk++;
      if (k == 1) begin
        if (bus.v_res_valid !== 1'b1 || bus.v_res_rdata !== 32'h0) begin
          $display("FAIL t5_store_res: got %b/%h want 1/0", bus.v_res_valid, bus.v_res_rdata);
          n_fail++; end
        n_chk++;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // Reset pulse right after a locking vector load drops the result and the lock.
  task automatic test_reset_midop();
    vec_req(3'd3, 32'hA000_0000, 1'b0, '0, 4'hF, 1'b0);
    @(negedge clk);
    if (bus.v_mem_ready !== 1'b1) begin
      $display("FAIL t6_accept: got %b want 1", bus.v_mem_ready); n_fail++; end
    n_chk++;
    next_cycle();
    resetb = 1'b0;
    clear_inputs();
    bus.c_rready = 1; bus.c_raddr = 32'hB000_0000;
    bus.c_wready = 1; bus.c_waddr = 32'hB000_0004; bus.c_wdata = 32'h1234_5678;
    bus.c_wstrb = 4'hF;
    @(negedge clk);
    if ({bus.m_rready, bus.m_wready, bus.c_rvalid, bus.c_wvalid, bus.v_res_valid} !== 5'b0) begin
      $display("FAIL t6_rst_ctrl: got %b want 00000", {bus.m_rready, bus.m_wready, bus.c_rvalid,
               bus.c_wvalid, bus.v_res_valid}); n_fail++; end
    n_chk++;
    if ({bus.m_raddr, bus.m_waddr, bus.m_wdata, bus.c_rdata, bus.v_res_id} !== '0) begin
      $display("FAIL t6_rst_data: got %h/%h/%h/%h/%h want all 0", bus.m_raddr, bus.m_waddr,
               bus.m_wdata, bus.c_rdata, bus.v_res_id); n_fail++; end
    n_chk++;
    next_cycle();
    bus.c_wready = 0;
    resetb = 1'b1;
    @(negedge clk);
    if (bus.c_rvalid !== 1'b1) begin
      $display("FAIL t6_lock_cleared: got c_rvalid=%b want 1", bus.c_rvalid); n_fail++; end
    n_chk++;
    next_cycle();
    bus.c_rready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (bus.v_res_valid !== 1'b0) begin
        $display("FAIL t6_no_res_k%0d: got %b want 0", k, bus.v_res_valid); n_fail++; end
      n_chk++;
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_read_contend();
    do_reset();
    test_starve();
    do_reset();
    test_burst_lock();
    do_reset();
    test_load_err();
    do_reset();
    test_lock_timeout();
    do_reset();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
